// File: rtl/fir4_inverse_u.sv
// fir4_inverse_u -- inverse of the team's unsigned 4-tap moving-sum FIR.
//
// The forward filter produces y_k = x_k + x_(k-1) + x_(k-2) + x_(k-3). This block
// undoes it with the recurrence x_k = y_k - y_(k-1) + x_(k-4). The arithmetic is
// (w+3)-bit two's complement and nothing is truncated along the way.
//
// Build option:
//   FIR4_INV_ERR_EN  When defined, each result is range-checked against [0, 2^w-1].
//                    A result outside that range raises a sticky err and parks the
//                    FSM in an error state until clr. When undefined, err is tied
//                    low and every accepted sample produces an output.
//
// Ports:
//   clk      sole clock, rising edge
//   reset    asynchronous active-low reset
//   s_in     (w+2)-bit moving-sum sample
//   s_valid  s_in carries a new sample this cycle
//   clr      synchronous clear of history, prime counter and error state
//   a_out    reconstructed sample (low w bits of x_k)
//   a_valid  one-cycle strobe marking a new a_out
//   primed   high once 4 outputs have been produced since reset/clr
//   err      sticky range error (0 unless FIR4_INV_ERR_EN)

module fir4_inverse_u #(
   parameter int unsigned w = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [w+1:0]   s_in,
   input  logic           s_valid,
   input  logic           clr,
   output logic [w-1:0]   a_out,
   output logic           a_valid,
   output logic           primed,
   output logic           err
);

   localparam int unsigned XW = w + 3;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StError = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   // hist_q[0] is x_(k-1), hist_q[3] is x_(k-4).
   logic [3:0][XW-1:0]     hist_q, hist_d;
   logic [w+1:0]           prev_y_q, prev_y_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [w-1:0]           a_out_q, a_out_d;
   logic                   a_valid_q, a_valid_d;

   // Both y operands are zero-extended, so the subtraction is exact in XW bits.
   logic [XW-1:0]          x_calc;
   assign x_calc = {1'b0, s_in} - {1'b0, prev_y_q} + hist_q[3];

`ifdef FIR4_INV_ERR_EN
   logic                   err_q, err_d;
   logic                   range_err;
   // Out of range when negative or when any bit above w-1 is set.
   assign range_err = x_calc[XW-1] | (|x_calc[XW-2:w]);
`endif

   always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      prev_y_d  = prev_y_q;
      cnt_d     = cnt_q;
      a_out_d   = a_out_q;
      a_valid_d = 1'b0;
`ifdef FIR4_INV_ERR_EN
      err_d     = err_q;
`endif

      if (clr) begin
         // clr wins over a simultaneous sample; a_out keeps its last value.
         state_d  = StIdle;
         hist_d   = '0;
         prev_y_d = '0;
         cnt_d    = '0;
`ifdef FIR4_INV_ERR_EN
         err_d    = 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle, StRun: begin
               if (s_valid) begin
                  hist_d    = {hist_q[2:0], x_calc};
                  prev_y_d  = s_in;
                  a_out_d   = x_calc[w-1:0];
                  a_valid_d = 1'b1;
                  state_d   = StRun;
                  if (cnt_q != 3'd4) begin
                     cnt_d = cnt_q + 3'd1;
                  end
`ifdef FIR4_INV_ERR_EN
                  if (range_err) begin
                     state_d = StError;
                     err_d   = 1'b1;
                  end
`endif
               end
            end
            StError: begin
               // Input ignored; everything frozen until clr.
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         hist_q    <= '0;
         prev_y_q  <= '0;
         cnt_q     <= '0;
         a_out_q   <= '0;
         a_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         prev_y_q  <= prev_y_d;
         cnt_q     <= cnt_d;
         a_out_q   <= a_out_d;
         a_valid_q <= a_valid_d;
      end
   end

`ifdef FIR4_INV_ERR_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign a_out   = a_out_q;
   assign a_valid = a_valid_q;
   assign primed  = (cnt_q == 3'd4);

endmodule

// File: doc/fir4_inverse_u.md
FIR4_INVERSE_U -- requirements
Module: fir4_inverse_u

Interface
REQ-001 Parameter w, default 16; width of one reconstructed sample.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port s_in  input  w+2  unsigned 4-tap moving-sum sample, as produced by the team's 4-tap FIR.
REQ-005 Port s_valid  input  1  s_in holds a new sample this cycle.
REQ-006 Port clr  input  1  synchronous clear of reconstruction history and error state.
REQ-007 Port a_out  output  w  reconstructed input sample.
REQ-008 Port a_valid  output  1  one-cycle strobe; a_out is new this cycle.
REQ-009 Port primed  output  1  high once 4 samples have been reconstructed since reset or clr.
REQ-010 Port err  output  1  sticky reconstruction-range error.

Function
REQ-011 Recurrence: x_k = y_k - y_(k-1) + x_(k-4), where y_k is the k-th accepted s_in and x_k is the k-th output; y_(-1) and x_(-1..-4) are 0.
REQ-012 Arithmetic in w+3-bit two's complement; no intermediate truncation.
REQ-013 Range: x_k in [0, 2^w-1]; otherwise range error, a_out = x_k[w-1:0].
REQ-014 Latency: s_valid sampled at edge N -> a_out/a_valid valid after edge N, i.e. exactly 1 cycle.
REQ-015 s_valid low: no history update, a_valid low, a_out holds.
REQ-016 History: 4-deep x shift register plus previous-y register, advancing only on accepted samples.
REQ-017 FSM states IDLE, RUN, ERROR; reset -> IDLE.
REQ-018 IDLE: first accepted sample -> RUN (sample processed normally).
REQ-019 RUN: range error on an accepted sample -> ERROR, err=1 same cycle as that a_valid.
REQ-020 ERROR: s_valid ignored, a_valid held 0, history frozen, err held 1.
REQ-021 clr (any state) -> IDLE next edge; history, prev-y, prime counter zeroed; err cleared; a_valid 0 that cycle.
REQ-022 clr and s_valid together: clr wins, sample discarded.
REQ-023 Prime counter 0..4, saturating, counts emitted outputs; primed = (count==4).
REQ-024 Range error also increments nothing further; counter frozen in ERROR.

Reset
REQ-025 reset low asynchronously forces: a_out=0, a_valid=0, primed=0, err=0, history=0, prev-y=0, counter=0, FSM=IDLE.
REQ-026 Reset release synchronous to clk; first sample accepted on first edge after release.
REQ-027 Reset asserted mid-stream discards in-flight sample; no a_valid after release until a new s_valid.

Configuration
REQ-028 Macro FIR4_INV_ERR_EN defined: range checking, ERROR state and err as above.
REQ-029 Macro FIR4_INV_ERR_EN undefined: no range check, ERROR unreachable, err tied 0, a_out always x_k[w-1:0], a_valid follows s_valid by 1 cycle unconditionally.

Verification
REQ-030 w=16; s_in 1,3,6,10,14,18 on consecutive cycles -> a_out 1,2,3,4,5,6, a_valid each cycle, primed high with 4th output.
REQ-031 Same stream with s_valid low 3 cycles between samples -> identical a_out sequence, a_valid only 1 cycle after each sample.
REQ-032 ERR_EN: s_in 5 then 2 -> a_out 5, then x=-3: err=1, state ERROR, later s_valid gives no a_valid until clr.
REQ-033 ERR_EN: first s_in 0x10000 -> err=1, a_out 0x0000; clr then s_in 7 -> err=0, a_out 7.
REQ-034 reset low after 2 samples of REQ-030 stream -> all outputs 0 immediately; restart with 1,3 -> a_out 1,2.
REQ-035 Without FIR4_INV_ERR_EN: s_in 5 then 2 -> a_out 5 then 0xFFFD, err stays 0.
